// File: rtl/cachepool_l2_id_remapper.sv
// Per-channel AXI ID remapper: compresses wide request IDs onto 2^MstIdWidth table entries, restores them on responses.
// Optional macro CACHEPOOL_IDREMAP_STATS_EN adds per-channel stall counters and active-entry high-water marks.
module cachepool_l2_id_remapper #(
    parameter int unsigned NumChannels  = 4,
    parameter int unsigned SlvIdWidth   = 6,
    parameter int unsigned MstIdWidth   = 2,
    parameter int unsigned MaxTxnsPerId = 4,
    localparam int unsigned CntWidth    = $clog2(MaxTxnsPerId + 1),
    localparam int unsigned NumEntries  = 1 << MstIdWidth
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumChannels-1:0]            slv_req_valid_i,
    output logic [NumChannels-1:0]            slv_req_ready_o,
    input  logic [NumChannels*SlvIdWidth-1:0] slv_req_id_i,
    output logic [NumChannels-1:0]            mst_req_valid_o,
    input  logic [NumChannels-1:0]            mst_req_ready_i,
    output logic [NumChannels*MstIdWidth-1:0] mst_req_id_o,
    input  logic [NumChannels-1:0]            mst_rsp_valid_i,
    output logic [NumChannels-1:0]            mst_rsp_ready_o,
    input  logic [NumChannels*MstIdWidth-1:0] mst_rsp_id_i,
    input  logic [NumChannels-1:0]            mst_rsp_last_i,
    output logic [NumChannels-1:0]            slv_rsp_valid_o,
    input  logic [NumChannels-1:0]            slv_rsp_ready_i,
    output logic [NumChannels*SlvIdWidth-1:0] slv_rsp_id_o,
`ifdef CACHEPOOL_IDREMAP_STATS_EN
    output logic [NumChannels*32-1:0]             stall_cnt_o,
    output logic [NumChannels*(MstIdWidth+1)-1:0] max_active_o,
`endif
    output logic [NumChannels-1:0]            error_o
);

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ch
        logic [NumEntries-1:0]                 active_reg, active_next;
        logic [NumEntries-1:0][SlvIdWidth-1:0] slv_id_reg, slv_id_next;
        logic [NumEntries-1:0][CntWidth-1:0]   cnt_reg, cnt_next;
        logic                                  error_reg, error_next;

        logic [SlvIdWidth-1:0] req_id;
        logic [MstIdWidth-1:0] rsp_id;
        logic                  hit, free;
        logic [MstIdWidth-1:0] hit_idx, free_idx, sel_idx;
        logic                  stall, req_hs, rsp_hs, rsp_active, release_hs;
        logic [NumEntries-1:0] inc_vec, dec_vec;

        assign req_id = slv_req_id_i[gi*SlvIdWidth +: SlvIdWidth];
        assign rsp_id = mst_rsp_id_i[gi*MstIdWidth +: MstIdWidth];

        // Lookup sees registered state only, so a release never opens req_ready in the same cycle.
        always_comb begin
            hit      = 1'b0;
            hit_idx  = '0;
            free     = 1'b0;
            free_idx = '0;
            for (int e = 0; e < NumEntries; e++) begin
                if (!hit && active_reg[e] && slv_id_reg[e] == req_id) begin
                    hit     = 1'b1;
                    hit_idx = MstIdWidth'(e);
                end
            end
            for (int e = NumEntries - 1; e >= 0; e--) begin
                if (!active_reg[e]) begin
                    free     = 1'b1;
                    free_idx = MstIdWidth'(e);
                end
            end
        end

        assign stall   = hit ? (cnt_reg[hit_idx] == CntWidth'(MaxTxnsPerId)) : !free;
        assign sel_idx = hit ? hit_idx : free_idx;

        assign mst_req_valid_o[gi] = slv_req_valid_i[gi] && !stall;
        assign slv_req_ready_o[gi] = mst_req_ready_i[gi] && !stall;
        assign mst_req_id_o[gi*MstIdWidth +: MstIdWidth] = sel_idx;
        assign req_hs = mst_req_valid_o[gi] && mst_req_ready_i[gi];

        assign slv_rsp_valid_o[gi] = mst_rsp_valid_i[gi];
        assign mst_rsp_ready_o[gi] = slv_rsp_ready_i[gi];
        assign rsp_active = active_reg[rsp_id];
        assign slv_rsp_id_o[gi*SlvIdWidth +: SlvIdWidth] = rsp_active ? slv_id_reg[rsp_id] : '0;
        assign rsp_hs     = mst_rsp_valid_i[gi] && slv_rsp_ready_i[gi];
        assign release_hs = rsp_hs && mst_rsp_last_i[gi] && rsp_active;

        always_comb begin
            inc_vec     = '0;
            dec_vec     = '0;
            active_next = active_reg;
            slv_id_next = slv_id_reg;
            cnt_next    = cnt_reg;
            error_next  = error_reg || (rsp_hs && !rsp_active);
            for (int e = 0; e < NumEntries; e++) begin
                inc_vec[e] = req_hs && (sel_idx == MstIdWidth'(e));
                dec_vec[e] = release_hs && (rsp_id == MstIdWidth'(e));
                case ({inc_vec[e], dec_vec[e]})
                    2'b10: begin
                        cnt_next[e]    = cnt_reg[e] + CntWidth'(1);
                        active_next[e] = 1'b1;
                        slv_id_next[e] = req_id;
                    end
                    2'b01: begin
                        cnt_next[e] = cnt_reg[e] - CntWidth'(1);
                        if (cnt_reg[e] == CntWidth'(1)) begin
                            active_next[e] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                active_reg <= '0;
                slv_id_reg <= '0;
                cnt_reg    <= '0;
                error_reg  <= 1'b0;
            end else begin
                active_reg <= active_next;
                slv_id_reg <= slv_id_next;
                cnt_reg    <= cnt_next;
                error_reg  <= error_next;
            end
        end

        assign error_o[gi] = error_reg;

`ifndef SYNTHESIS
        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                for (int e = 0; e < NumEntries; e++) begin
                    assert (cnt_reg[e] <= CntWidth'(MaxTxnsPerId))
                        else $error("cnt overflow ch%0d entry%0d", gi, e);
                    assert (!(dec_vec[e] && !inc_vec[e] && cnt_reg[e] == '0))
                        else $error("cnt underflow ch%0d entry%0d", gi, e);
                end
            end
        end
`endif

`ifdef CACHEPOOL_IDREMAP_STATS_EN
        logic [31:0]         stall_cnt_reg;
        logic [MstIdWidth:0] max_active_reg, num_active;

        always_comb begin
            num_active = '0;
            for (int e = 0; e < NumEntries; e++) begin
                num_active = num_active + (MstIdWidth+1)'(active_reg[e]);
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stall_cnt_reg  <= '0;
                max_active_reg <= '0;
            end else begin
                if (slv_req_valid_i[gi] && stall && stall_cnt_reg != '1) begin
                    stall_cnt_reg <= stall_cnt_reg + 32'd1;
                end
                if (num_active > max_active_reg) begin
                    max_active_reg <= num_active;
                end
            end
        end

        assign stall_cnt_o[gi*32 +: 32]                          = stall_cnt_reg;
        assign max_active_o[gi*(MstIdWidth+1) +: (MstIdWidth+1)] = max_active_reg;
`endif
    end

endmodule

// File: tb/tb_cachepool_l2_id_remapper.sv
// Directed table-driven bench for cachepool_l2_id_remapper (default parameters, channel 0 vectors plus channel 1 isolation).
module tb_cachepool_l2_id_remapper;
    localparam int NC = 4;
    localparam int SW = 6;
    localparam int MW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]    slv_req_valid, slv_req_ready, mst_req_valid, mst_req_ready;
    logic [NC*SW-1:0] slv_req_id, slv_rsp_id;
    logic [NC*MW-1:0] mst_req_id, mst_rsp_id;
    logic [NC-1:0]    mst_rsp_valid, mst_rsp_ready, mst_rsp_last;
    logic [NC-1:0]    slv_rsp_valid, slv_rsp_ready, error;
`ifdef CACHEPOOL_IDREMAP_STATS_EN
    logic [NC*32-1:0]     stall_cnt;
    logic [NC*(MW+1)-1:0] max_active;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cachepool_l2_id_remapper dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .slv_req_valid_i (slv_req_valid),
        .slv_req_ready_o (slv_req_ready),
        .slv_req_id_i    (slv_req_id),
        .mst_req_valid_o (mst_req_valid),
        .mst_req_ready_i (mst_req_ready),
        .mst_req_id_o    (mst_req_id),
        .mst_rsp_valid_i (mst_rsp_valid),
        .mst_rsp_ready_o (mst_rsp_ready),
        .mst_rsp_id_i    (mst_rsp_id),
        .mst_rsp_last_i  (mst_rsp_last),
        .slv_rsp_valid_o (slv_rsp_valid),
        .slv_rsp_ready_i (slv_rsp_ready),
        .slv_rsp_id_o    (slv_rsp_id),
`ifdef CACHEPOOL_IDREMAP_STATS_EN
        .stall_cnt_o     (stall_cnt),
        .max_active_o    (max_active),
`endif
        .error_o         (error)
    );

    typedef struct {
        logic       rv;
        logic [5:0] rid;
        logic       mrdy;
        logic       pv;
        logic [1:0] pid;
        logic       plast;
        logic       e_rdy;
        logic       e_mv;
        logic [1:0] e_mid;
        logic [5:0] e_sid;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rv, logic [5:0] rid, logic mrdy, logic pv, logic [1:0] pid,
                                logic plast, logic e_rdy, logic e_mv, logic [1:0] e_mid,
                                logic [5:0] e_sid, logic e_err);
        vec_t v;
        v.rv = rv; v.rid = rid; v.mrdy = mrdy; v.pv = pv; v.pid = pid; v.plast = plast;
        v.e_rdy = e_rdy; v.e_mv = e_mv; v.e_mid = e_mid; v.e_sid = e_sid; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h exp=%h", name, idx, act, exp);
        end
    endtask

    task automatic idle_all();
        slv_req_valid = '0;
        slv_req_id    = '0;
        mst_req_ready = '1;
        mst_rsp_valid = '0;
        mst_rsp_id    = '0;
        mst_rsp_last  = '0;
        slv_rsp_ready = '1;
    endtask

    task automatic drive(int ch, logic rv, logic [5:0] rid, logic mrdy, logic pv, logic [1:0] pid, logic plast);
        slv_req_valid[ch]        = rv;
        slv_req_id[ch*SW +: SW]  = rid;
        mst_req_ready[ch]        = mrdy;
        mst_rsp_valid[ch]        = pv;
        mst_rsp_id[ch*MW +: MW]  = pid;
        mst_rsp_last[ch]         = plast;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        idle_all();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        // rv rid mrdy pv pid last | rdy mv mid sid err
        vecs.push_back(mk(1, 6'h2A, 1, 0, 0, 0, 1, 1, 0, 6'h00, 0));
        vecs.push_back(mk(0, 6'h00, 1, 1, 0, 1, 1, 0, 0, 6'h2A, 0));
        vecs.push_back(mk(1, 6'h05, 1, 0, 0, 0, 1, 1, 0, 6'h00, 0));
        vecs.push_back(mk(0, 6'h00, 1, 1, 0, 1, 1, 0, 0, 6'h05, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 6'h11, 1, 0, 0, 0, 1, 1, 0, 6'h00, 0));
        vecs.push_back(mk(1, 6'h11, 1, 0, 0, 0, 0, 0, 0, 6'h00, 0));
        vecs.push_back(mk(1, 6'h11, 1, 1, 0, 1, 0, 0, 0, 6'h11, 0));
        vecs.push_back(mk(1, 6'h11, 1, 0, 0, 0, 1, 1, 0, 6'h00, 0));
        vecs.push_back(mk(0, 6'h00, 1, 1, 0, 0, 1, 0, 0, 6'h11, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(0, 6'h00, 1, 1, 0, 1, 1, 0, 0, 6'h11, 0));
        vecs.push_back(mk(1, 6'h01, 1, 0, 0, 0, 1, 1, 0, 6'h00, 0));
        vecs.push_back(mk(1, 6'h02, 1, 0, 0, 0, 1, 1, 1, 6'h00, 0));
        vecs.push_back(mk(1, 6'h03, 1, 0, 0, 0, 1, 1, 2, 6'h00, 0));
        vecs.push_back(mk(1, 6'h04, 1, 0, 0, 0, 1, 1, 3, 6'h00, 0));
        vecs.push_back(mk(1, 6'h05, 1, 0, 0, 0, 0, 0, 0, 6'h00, 0));
        vecs.push_back(mk(1, 6'h05, 1, 1, 2, 1, 0, 0, 0, 6'h03, 0));
        vecs.push_back(mk(1, 6'h05, 1, 0, 0, 0, 1, 1, 2, 6'h00, 0));
        vecs.push_back(mk(1, 6'h02, 1, 0, 0, 0, 1, 1, 1, 6'h00, 0));
        vecs.push_back(mk(1, 6'h02, 1, 1, 1, 1, 1, 1, 1, 6'h02, 0));
        vecs.push_back(mk(0, 6'h00, 1, 1, 1, 1, 0, 0, 0, 6'h02, 0));
        vecs.push_back(mk(0, 6'h00, 1, 1, 1, 1, 0, 0, 0, 6'h02, 0));
        vecs.push_back(mk(1, 6'h06, 1, 0, 0, 0, 1, 1, 1, 6'h00, 0));
        vecs.push_back(mk(0, 6'h00, 1, 1, 3, 1, 0, 0, 0, 6'h04, 0));
        vecs.push_back(mk(0, 6'h00, 1, 1, 3, 1, 1, 0, 0, 6'h00, 0));
        vecs.push_back(mk(0, 6'h00, 1, 0, 0, 0, 1, 0, 0, 6'h00, 1));
        vecs.push_back(mk(1, 6'h07, 0, 0, 0, 0, 0, 1, 3, 6'h00, 1));
        vecs.push_back(mk(1, 6'h07, 1, 0, 0, 0, 1, 1, 3, 6'h00, 1));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("reset_mst_valid", -1, 32'(mst_req_valid), 32'h0);
        chk("reset_rsp_valid", -1, 32'(slv_rsp_valid), 32'h0);
        chk("reset_error", -1, 32'(error), 32'h0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(0, vecs[i].rv, vecs[i].rid, vecs[i].mrdy, vecs[i].pv, vecs[i].pid, vecs[i].plast);
            #2;
            $display("vec %0d ch0 req_id=%h rdy=%b mst_valid=%b mst_id=%0d rsp_id=%h err=%b", i,
                     vecs[i].rid, slv_req_ready[0], mst_req_valid[0], mst_req_id[MW-1:0],
                     slv_rsp_id[SW-1:0], error[0]);
            chk("req_ready", i, 32'(slv_req_ready[0]), 32'(vecs[i].e_rdy));
            chk("mst_valid", i, 32'(mst_req_valid[0]), 32'(vecs[i].e_mv));
            if (vecs[i].e_mv) chk("mst_id", i, 32'(mst_req_id[MW-1:0]), 32'(vecs[i].e_mid));
            if (vecs[i].pv) begin
                chk("rsp_valid", i, 32'(slv_rsp_valid[0]), 32'h1);
                chk("rsp_id", i, 32'(slv_rsp_id[SW-1:0]), 32'(vecs[i].e_sid));
            end
            chk("error", i, 32'(error[0]), 32'(vecs[i].e_err));
        end

        // Reset while entries are busy: table empties and the sticky error clears.
        do_reset();
        #2;
        chk("rst_error", 100, 32'(error[0]), 32'h0);
        drive(0, 1, 6'h3F, 1, 1, 1, 1);
        #1;
        $display("mid-reset ch0 req_id=3f rdy=%b mst_id=%0d rsp_id=%h", slv_req_ready[0],
                 mst_req_id[MW-1:0], slv_rsp_id[SW-1:0]);
        chk("rst_req_ready", 101, 32'(slv_req_ready[0]), 32'h1);
        chk("rst_mst_id", 101, 32'(mst_req_id[MW-1:0]), 32'h0);
        chk("rst_orphan_rsp_id", 101, 32'(slv_rsp_id[SW-1:0]), 32'h0);
        @(posedge clk);
        #1 idle_all();
        #2 chk("orphan_error", 102, 32'(error[0]), 32'h1);

        // Channel 0 saturated on one ID must not affect channel 1.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 6'h11, 1, 0, 0, 0);
            @(posedge clk);
            #1;
        end
        drive(0, 1, 6'h11, 1, 0, 0, 0);
        drive(1, 1, 6'h22, 1, 0, 0, 0);
        #2;
        $display("iso ch0 rdy=%b ch1 rdy=%b ch1 mst_id=%0d", slv_req_ready[0], slv_req_ready[1],
                 mst_req_id[2*MW-1:MW]);
        chk("iso_ch0_stall", 200, 32'(slv_req_ready[0]), 32'h0);
        chk("iso_ch1_ready", 200, 32'(slv_req_ready[1]), 32'h1);
        chk("iso_ch1_valid", 200, 32'(mst_req_valid[1]), 32'h1);
        chk("iso_ch1_mst_id", 200, 32'(mst_req_id[2*MW-1:MW]), 32'h0);
        @(posedge clk);
        #1 idle_all();
        drive(1, 0, 6'h00, 1, 1, 0, 1);
        #2;
        $display("iso ch1 rsp_id=%h err=%b", slv_rsp_id[2*SW-1:SW], error[1]);
        chk("iso_ch1_rsp_id", 201, 32'(slv_rsp_id[2*SW-1:SW]), 32'h22);
        chk("iso_ch1_error", 201, 32'(error[1]), 32'h0);
        @(posedge clk);
        #1 idle_all();

`ifdef CACHEPOOL_IDREMAP_STATS_EN
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive(0, 1, 6'(k), 1, 0, 0, 0);
            @(posedge clk);
            #1;
        end
        drive(0, 1, 6'h05, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 idle_all();
        @(posedge clk);
        #2;
        $display("stats ch0 stall_cnt=%0d max_active=%0d", stall_cnt[31:0], max_active[MW:0]);
        chk("stall_cnt", 300, stall_cnt[31:0], 32'd3);
        chk("max_active", 300, 32'(max_active[MW:0]), 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
